ptr_ka10: RTL and testbench
===========================

# ptr_ka10

KA10 paper tape reader (device 104) for the PDP-10 FPGA. It answers CONO/CONI/DATAI on the I/O bus and pulls tape frames from the host front end over a slave write port. It assembles frames into the read buffer in alpha or binary mode and raises a PI request when a character or word is ready. It is the input-side counterpart of the tape punch, `ptp_ka10`, and uses the same bus and front-end port style.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low; clears all state.
- iobus_iob_poweron  in  1  low = hold block in reset state, synchronous.
- iobus_iob_reset  in  1  I/O reset; same effect as CONO clear.
- iobus_datao_clear, iobus_datao_set  in  1 each  ignored; reader has no DATAO.
- iobus_cono_clear, iobus_cono_set  in  1 each  CONO strobes.
- iobus_iob_fm_datai, iobus_iob_fm_status  in  1 each  DATAI / CONI strobes.
- iobus_ios  in  [3:9]  device select; the block is selected when it equals 7'b001_000_1.
- iobus_iob_in  in  [0:35]  CONO data.
- iobus_pi_req  out  [1:7]  PI request lines.
- iobus_iob_out  out  [0:35]  DATAI/CONI data; 0 when not driving.
- s_write  in  1  front-end frame write strobe, one clock.
- s_writedata  in  32  frame data; bits 7:0 = holes 8..1.
- s_read  in  1  front-end status read.
- s_readdata  out  32  status: bit0 busy, bit1 done, bit2 binary, bits 5:3 frame count, rest 0.
- fe_data_rq  out  1  reader wants a frame.

## Operation
- Registers: pia[33:35], done, busy, binary, fcnt (0..5), buf[0:35].
- All bus strobes are edge-detected: the action fires once on the first clock with the strobe high and selected. Strobes may stay high for many cycles.
- CONO clear, iob_reset, or poweron low clears pia, done, busy, binary, fcnt and buf.
- CONO set ORs in the following iob_in bits: 33:35 into pia, 32 into done, 31 into busy, 30 into binary.
- CONI (fm_status, selected) drives iob_out as: 30 binary, 31 busy, 32 done, 33:35 pia, all other bits 0.
- DATAI (fm_datai, selected) drives iob_out with buf. On the strobe edge it clears done, clears fcnt and sets busy (read-ahead).
- iob_out is combinational and is 0 whenever no selected strobe is high.
- fe_data_rq is busy & ~done.
- s_write is accepted only while fe_data_rq=1 and is otherwise ignored.
- Alpha mode (binary=0): buf is set to {28'b0, frame[7:0]}. Then done=1 and busy=0.
- Binary mode, frame with hole 8 clear (bit7=0): the frame is discarded and fcnt is unchanged.
- Binary mode, frame with bit7=1: buf is set to {buf[6:35], frame[5:0]} and fcnt increments.
  - On the 6th frame (fcnt was 5), fcnt wraps to 0, done=1 and busy=0.
- iobus_pi_req[pia]=done when pia≠0. All pi_req lines are 0 when pia=0.
- Simultaneous events, priority highest first: reset, then CONO clear, then CONO set, then DATAI, then s_write.
  - If CONO clear and s_write occur together, the frame is dropped.
  - If CONO set and s_write occur together, the frame is processed with the pre-CONO mode.

## Timing
- Reset values: iobus_pi_req=0, iobus_iob_out=0, s_readdata=0, fe_data_rq=0, buf=0.
- Strobe to register update: the update happens on the first rising edge that samples the strobe high. Outputs reflect it the next cycle.
- fe_data_rq rises 1 cycle after busy is set. It falls the cycle after the completing s_write.
- s_write to done: 1 clock in alpha mode, 1 clock after the 6th valid frame in binary mode.
- done to pi_req: combinational, 0 extra cycles.
- s_readdata is valid combinationally while s_read is high and is 0 otherwise.
- Reset asserted mid-word: the partial word is lost and fcnt returns to 0.

## Configuration
- PTR_BINARY_EN defined: binary mode is built in as described above.
- PTR_BINARY_EN undefined:
  - The binary register is removed; CONO bit 30 is ignored and CONI bit 30 and s_readdata bit2 read 0.
  - fcnt reads 0.
  - Every accepted frame follows alpha mode.

## Test plan
- Reset, then CONO set iob_in=36'o20 with ios=001_000_1 → fe_data_rq=1. Then s_write 'o215 → done=1, fe_data_rq=0, and DATAI returns 36'o215.
- CONO set 36'o23 (busy, pia=3), then s_write 'o101 → iobus_pi_req=7'b0010000. DATAI drops pi_req and re-raises fe_data_rq.
- Binary mode (CONO 36'o60): frames 'o201,'o002,'o202,'o203,'o204,'o205,'o206 → the 'o002 frame is skipped and done is set after the 6th valid frame. DATAI returns 36'o010203040506.
- Binary mode, 3 valid frames, then CONO clear held 10 cycles → buf=0, fcnt=0, busy=0. Only one clear action occurs; CONI returns 0.
- ios=001_000_0 with fm_status high → iob_out=0. s_write while busy=0 → ignored and buf unchanged.
- Build without PTR_BINARY_EN, CONO 36'o60 → CONI returns 36'o20. Frame 'o377 → DATAI returns 36'o377.

Source files
------------

// File: rtl/ptr_ka10.sv
// rtl/ptr_ka10.sv - KA10 paper tape reader (device 104), alpha/binary frame assembly.
// Binary mode is built only when PTR_BINARY_EN is defined.
module ptr_ka10 (
  input  logic        clk,
  input  logic        reset,
  input  logic        iobus_iob_poweron,
  input  logic        iobus_iob_reset,
  input  logic        iobus_datao_clear,
  input  logic        iobus_datao_set,
  input  logic        iobus_cono_clear,
  input  logic        iobus_cono_set,
  input  logic        iobus_iob_fm_datai,
  input  logic        iobus_iob_fm_status,
  input  logic [3:9]  iobus_ios,
  input  logic [0:35] iobus_iob_in,
  output logic [1:7]  iobus_pi_req,
  output logic [0:35] iobus_iob_out,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  input  logic        s_read,
  output logic [31:0] s_readdata,
  output logic        fe_data_rq
);

  logic        sel;
  logic        clr_lvl_q, clr_lvl_d;
  logic        set_lvl_q, set_lvl_d;
  logic        dti_lvl_q, dti_lvl_d;
  logic        clr_edge, set_edge, dti_edge;
  logic [33:35] pia_q, pia_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic [0:35] rbuf_q, rbuf_d;
  logic        accept;
  logic [0:35] coni_w;

`ifdef PTR_BINARY_EN
  logic        binary_q, binary_d;
  logic [2:0]  fcnt_q, fcnt_d;
`else
  logic        binary_q;
  logic [2:0]  fcnt_q;
  assign binary_q = 1'b0;
  assign fcnt_q   = 3'd0;
`endif

  wire unused_ok = &{1'b0, iobus_datao_clear, iobus_datao_set, iobus_iob_in[0:30],
                     s_writedata[31:8]};

  assign sel       = (iobus_ios == 7'b001_000_1);
  assign clr_lvl_d = sel & iobus_cono_clear;
  assign set_lvl_d = sel & iobus_cono_set;
  assign dti_lvl_d = sel & iobus_iob_fm_datai;
  assign clr_edge  = clr_lvl_d & ~clr_lvl_q;
  assign set_edge  = set_lvl_d & ~set_lvl_q;
  assign dti_edge  = dti_lvl_d & ~dti_lvl_q;

  assign fe_data_rq = busy_q & ~done_q;
  assign accept     = s_write & fe_data_rq;

  // Lowest priority event is applied first so later (higher priority) ones override it.
  always_comb begin
    pia_d  = pia_q;
    done_d = done_q;
    busy_d = busy_q;
    rbuf_d = rbuf_q;
`ifdef PTR_BINARY_EN
    binary_d = binary_q;
    fcnt_d   = fcnt_q;
`endif
    if (accept) begin
      if (binary_q) begin
`ifdef PTR_BINARY_EN
        if (s_writedata[7]) begin
          rbuf_d = {rbuf_q[6:35], s_writedata[5:0]};
          if (fcnt_q == 3'd5) begin
            fcnt_d = 3'd0;
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            fcnt_d = fcnt_q + 3'd1;
          end
        end
`endif
      end else begin
        rbuf_d = {28'b0, s_writedata[7:0]};
        done_d = 1'b1;
        busy_d = 1'b0;
      end
    end
    if (dti_edge) begin
      done_d = 1'b0;
      busy_d = 1'b1;
`ifdef PTR_BINARY_EN
      fcnt_d = 3'd0;
`endif
    end
    if (set_edge) begin
      pia_d  = pia_q | iobus_iob_in[33:35];
      done_d = done_d | iobus_iob_in[32];
      busy_d = busy_d | iobus_iob_in[31];
`ifdef PTR_BINARY_EN
      binary_d = binary_d | iobus_iob_in[30];
`endif
    end
    if (clr_edge || iobus_iob_reset || !iobus_iob_poweron) begin
      pia_d  = 3'd0;
      done_d = 1'b0;
      busy_d = 1'b0;
      rbuf_d = 36'd0;
`ifdef PTR_BINARY_EN
      binary_d = 1'b0;
      fcnt_d   = 3'd0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_lvl_q <= 1'b0;
      set_lvl_q <= 1'b0;
      dti_lvl_q <= 1'b0;
      pia_q     <= 3'd0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      rbuf_q    <= 36'd0;
`ifdef PTR_BINARY_EN
      binary_q  <= 1'b0;
      fcnt_q    <= 3'd0;
`endif
    end else begin
      clr_lvl_q <= clr_lvl_d;
      set_lvl_q <= set_lvl_d;
      dti_lvl_q <= dti_lvl_d;
      pia_q     <= pia_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      rbuf_q    <= rbuf_d;
`ifdef PTR_BINARY_EN
      binary_q  <= binary_d;
      fcnt_q    <= fcnt_d;
`endif
    end
  end

  always_comb begin
    iobus_pi_req = 7'd0;
    for (int i = 1; i <= 7; i++) begin
      iobus_pi_req[i] = done_q && (pia_q == i[2:0]);
    end
  end

  always_comb begin
    coni_w        = 36'd0;
    coni_w[30]    = binary_q;
    coni_w[31]    = busy_q;
    coni_w[32]    = done_q;
    coni_w[33:35] = pia_q;
  end

  always_comb begin
    iobus_iob_out = 36'd0;
    if (sel && iobus_iob_fm_status) iobus_iob_out = iobus_iob_out | coni_w;
    if (sel && iobus_iob_fm_datai)  iobus_iob_out = iobus_iob_out | rbuf_q;
  end

  assign s_readdata = s_read ? {26'd0, fcnt_q, binary_q, done_q, busy_q} : 32'd0;

endmodule

// File: tb/tb_ptr_ka10.sv
// tb/tb_ptr_ka10.sv - directed self-checking bench for ptr_ka10 (either PTR_BINARY_EN build).
module tb_ptr_ka10;

  localparam logic [3:9] SEL   = 7'b001_000_1;
  localparam logic [3:9] UNSEL = 7'b001_000_0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        iobus_iob_poweron = 1'b1;
  logic        iobus_iob_reset = 1'b0;
  logic        iobus_datao_clear = 1'b0;
  logic        iobus_datao_set = 1'b0;
  logic        iobus_cono_clear = 1'b0;
  logic        iobus_cono_set = 1'b0;
  logic        iobus_iob_fm_datai = 1'b0;
  logic        iobus_iob_fm_status = 1'b0;
  logic [3:9]  iobus_ios = SEL;
  logic [0:35] iobus_iob_in = 36'd0;
  logic [1:7]  iobus_pi_req;
  logic [0:35] iobus_iob_out;
  logic        s_write = 1'b0;
  logic [31:0] s_writedata = 32'd0;
  logic        s_read = 1'b0;
  logic [31:0] s_readdata;
  logic        fe_data_rq;

  int n_cmp = 0;
  int n_fail = 0;

  ptr_ka10 dut (
    .clk(clk), .reset(reset), .iobus_iob_poweron(iobus_iob_poweron),
    .iobus_iob_reset(iobus_iob_reset), .iobus_datao_clear(iobus_datao_clear),
    .iobus_datao_set(iobus_datao_set), .iobus_cono_clear(iobus_cono_clear),
    .iobus_cono_set(iobus_cono_set), .iobus_iob_fm_datai(iobus_iob_fm_datai),
    .iobus_iob_fm_status(iobus_iob_fm_status), .iobus_ios(iobus_ios),
    .iobus_iob_in(iobus_iob_in), .iobus_pi_req(iobus_pi_req),
    .iobus_iob_out(iobus_iob_out), .s_write(s_write), .s_writedata(s_writedata),
    .s_read(s_read), .s_readdata(s_readdata), .fe_data_rq(fe_data_rq)
  );

  always #5 clk = ~clk;

  task automatic cono_set_op(input logic [0:35] v);
    @(negedge clk);
    iobus_ios = SEL; iobus_iob_in = v; iobus_cono_set = 1'b1;
    @(negedge clk);
    iobus_cono_set = 1'b0; iobus_iob_in = 36'd0;
  endtask

  task automatic cono_clear_op;
    @(negedge clk);
    iobus_ios = SEL; iobus_cono_clear = 1'b1;
    @(negedge clk);
    iobus_cono_clear = 1'b0;
  endtask

  task automatic write_frame(input logic [7:0] f);
    @(negedge clk);
    s_write = 1'b1; s_writedata = {24'd0, f};
    @(negedge clk);
    s_write = 1'b0; s_writedata = 32'd0;
  endtask

  task automatic datai_op(output logic [0:35] v);
    @(negedge clk);
    iobus_ios = SEL; iobus_iob_fm_datai = 1'b1;
    #1 v = iobus_iob_out;
    @(negedge clk);
    iobus_iob_fm_datai = 1'b0;
  endtask

  task automatic coni_op(output logic [0:35] v);
    @(negedge clk);
    iobus_ios = SEL; iobus_iob_fm_status = 1'b1;
    #1 v = iobus_iob_out;
    @(negedge clk);
    iobus_iob_fm_status = 1'b0;
  endtask

  task automatic status_rd(output logic [31:0] v);
    s_read = 1'b1;
    #1 v = s_readdata;
    s_read = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] st;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    iobus_iob_fm_status = 1'b1;
    #1;
    n_cmp++; if (iobus_iob_out !== 36'd0) begin n_fail++; $display("FAIL reset_iob_out got %o want 0", iobus_iob_out); end
    iobus_iob_fm_status = 1'b0;
    status_rd(st);
    n_cmp++; if (st !== 32'd0) begin n_fail++; $display("FAIL reset_readdata got %h want 0", st); end
    n_cmp++; if (iobus_pi_req !== 7'd0) begin n_fail++; $display("FAIL reset_pi_req got %b want 0", iobus_pi_req); end
    n_cmp++; if (fe_data_rq !== 1'b0) begin n_fail++; $display("FAIL reset_fe_data_rq got %b want 0", fe_data_rq); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_alpha;
    logic [0:35] v;
    logic [31:0] st;
    cono_set_op(36'o20);
    n_cmp++; if (fe_data_rq !== 1'b1) begin n_fail++; $display("FAIL alpha_rq_up got %b want 1", fe_data_rq); end
    write_frame(8'o215);
    n_cmp++; if (fe_data_rq !== 1'b0) begin n_fail++; $display("FAIL alpha_rq_down got %b want 0", fe_data_rq); end
    status_rd(st);
    n_cmp++; if (st !== 32'h2) begin n_fail++; $display("FAIL alpha_status got %h want 2", st); end
    datai_op(v);
    n_cmp++; if (v !== 36'o215) begin n_fail++; $display("FAIL alpha_datai got %o want 215", v); end
    n_cmp++; if (fe_data_rq !== 1'b1) begin n_fail++; $display("FAIL alpha_readahead got %b want 1", fe_data_rq); end
    cono_clear_op();
  endtask

  task automatic test_pi;
    logic [0:35] v;
    cono_set_op(36'o23);
    n_cmp++; if (iobus_pi_req !== 7'b0000000) begin n_fail++; $display("FAIL pi_idle got %b want 0000000", iobus_pi_req); end
    write_frame(8'o101);
    n_cmp++; if (iobus_pi_req !== 7'b0010000) begin n_fail++; $display("FAIL pi_req got %b want 0010000", iobus_pi_req); end
    datai_op(v);
    n_cmp++; if (v !== 36'o101) begin n_fail++; $display("FAIL pi_datai got %o want 101", v); end
    n_cmp++; if (iobus_pi_req !== 7'b0000000) begin n_fail++; $display("FAIL pi_drop got %b want 0000000", iobus_pi_req); end
    n_cmp++; if (fe_data_rq !== 1'b1) begin n_fail++; $display("FAIL pi_rq_again got %b want 1", fe_data_rq); end
    cono_clear_op();
  endtask

  task automatic test_deselect;
    logic [0:35] v;
    cono_set_op(36'o20);
    write_frame(8'o123);
    write_frame(8'o077);
    @(negedge clk);
    iobus_ios = UNSEL; iobus_iob_fm_status = 1'b1;
    #1;
    n_cmp++; if (iobus_iob_out !== 36'd0) begin n_fail++; $display("FAIL unsel_coni got %o want 0", iobus_iob_out); end
    iobus_iob_fm_status = 1'b0; iobus_iob_in = 36'o07; iobus_cono_set = 1'b1;
    @(negedge clk);
    iobus_cono_set = 1'b0; iobus_iob_in = 36'd0; iobus_ios = SEL;
    coni_op(v);
    n_cmp++; if (v !== 36'o10) begin n_fail++; $display("FAIL unsel_cono got %o want 10", v); end
    datai_op(v);
    n_cmp++; if (v !== 36'o123) begin n_fail++; $display("FAIL idle_write got %o want 123", v); end
    cono_clear_op();
  endtask

  task automatic test_back_to_back;
    logic [0:35] v;
    cono_set_op(36'o20);
    @(negedge clk);
    iobus_cono_clear = 1'b1; s_write = 1'b1; s_writedata = 32'o55;
    @(negedge clk);
    iobus_cono_clear = 1'b0; s_write = 1'b0; s_writedata = 32'd0;
    n_cmp++; if (fe_data_rq !== 1'b0) begin n_fail++; $display("FAIL clr_write_rq got %b want 0", fe_data_rq); end
    datai_op(v);
    n_cmp++; if (v !== 36'd0) begin n_fail++; $display("FAIL clr_write_drop got %o want 0", v); end
    cono_clear_op();
    @(negedge clk);
    iobus_cono_clear = 1'b1;
    repeat (3) @(negedge clk);
    iobus_iob_in = 36'o20; iobus_cono_set = 1'b1;
    @(negedge clk);
    iobus_cono_set = 1'b0; iobus_iob_in = 36'd0;
    repeat (3) @(negedge clk);
    iobus_cono_clear = 1'b0;
    coni_op(v);
    n_cmp++; if (v !== 36'o20) begin n_fail++; $display("FAIL held_clear_once got %o want 20", v); end
    cono_clear_op();
  endtask

`ifdef PTR_BINARY_EN
  task automatic test_binary;
    logic [0:35] v;
    logic [31:0] st;
    cono_set_op(36'o60);
    write_frame(8'o201);
    write_frame(8'o002);
    status_rd(st);
    n_cmp++; if (st !== 32'd13) begin n_fail++; $display("FAIL bin_skip got %h want d", st); end
    write_frame(8'o202); write_frame(8'o203); write_frame(8'o204); write_frame(8'o205);
    n_cmp++; if (fe_data_rq !== 1'b1) begin n_fail++; $display("FAIL bin_not_done got %b want 1", fe_data_rq); end
    write_frame(8'o206);
    status_rd(st);
    n_cmp++; if (st !== 32'd6) begin n_fail++; $display("FAIL bin_done got %h want 6", st); end
    datai_op(v);
    n_cmp++; if (v !== 36'o010203040506) begin n_fail++; $display("FAIL bin_word got %o want 010203040506", v); end
    cono_clear_op();
  endtask

  task automatic test_clear_held;
    logic [0:35] v;
    logic [31:0] st;
    cono_set_op(36'o60);
    write_frame(8'o201); write_frame(8'o202); write_frame(8'o203);
    @(negedge clk);
    iobus_cono_clear = 1'b1;
    repeat (10) @(negedge clk);
    iobus_cono_clear = 1'b0;
    status_rd(st);
    n_cmp++; if (st !== 32'd0) begin n_fail++; $display("FAIL held_status got %h want 0", st); end
    coni_op(v);
    n_cmp++; if (v !== 36'd0) begin n_fail++; $display("FAIL held_coni got %o want 0", v); end
    datai_op(v);
    n_cmp++; if (v !== 36'd0) begin n_fail++; $display("FAIL held_buf got %o want 0", v); end
    cono_clear_op();
  endtask
`else
  task automatic test_no_binary;
    logic [0:35] v;
    logic [31:0] st;
    cono_set_op(36'o60);
    coni_op(v);
    n_cmp++; if (v !== 36'o20) begin n_fail++; $display("FAIL nobin_coni got %o want 20", v); end
    status_rd(st);
    n_cmp++; if (st !== 32'd1) begin n_fail++; $display("FAIL nobin_status got %h want 1", st); end
    write_frame(8'o377);
    datai_op(v);
    n_cmp++; if (v !== 36'o377) begin n_fail++; $display("FAIL nobin_datai got %o want 377", v); end
    cono_clear_op();
  endtask
`endif

  initial begin
    test_reset();
    test_alpha();
    test_pi();
    test_deselect();
    test_back_to_back();
`ifdef PTR_BINARY_EN
    test_binary();
    test_clear_held();
`else
    test_no_binary();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
